// File: rtl/adau_spi_master.sv
// adau_spi_master: 32-bit SPI control-port master for ADAU codecs (CLATCH/CCLK/CDATA).
// Define ADAU_SPI_READBACK_EN to capture the last byte shifted in on spi_miso.
module adau_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] command,
    input  logic        command_valid,
    output logic        spi_ready,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [7:0]  rx_data,
    output logic        rx_valid
);
    localparam int unsigned CMD_W = 32;
    localparam int unsigned BIT_W = 5;
    localparam int unsigned PH_W  = 8;
    localparam int unsigned RX_W  = 8;
    localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(CMD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    logic [CMD_W-1:0] cmd_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [PH_W-1:0]  phase_cnt;
    logic             phase_done;

    assign phase_done = (phase_cnt == DIV_LAST);

`ifdef ADAU_SPI_READBACK_EN
    logic [RX_W-1:0] rx_shift;
`else
    logic unused_miso;

    assign unused_miso = spi_miso;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
`endif

    // Frame sequencer; all pins are registered and change only on clk edges
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            spi_ready <= 1'b1;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b1;
            spi_mosi  <= 1'b0;
`ifdef ADAU_SPI_READBACK_EN
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
`endif
        end else begin
`ifdef ADAU_SPI_READBACK_EN
            rx_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (command_valid) begin
                        state     <= SETUP;
                        cmd_q     <= command;
                        bit_cnt   <= BIT_FIRST;
                        phase_cnt <= '0;
                        spi_ready <= 1'b0;
                        spi_cs_n  <= 1'b0;
                        spi_sclk  <= 1'b1;
                        spi_mosi  <= command[CMD_W-1];
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        state     <= SHIFT;
                        phase_cnt <= '0;
                        spi_sclk  <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                SHIFT: begin
                    if (!phase_done) begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end else begin
                        phase_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
`ifdef ADAU_SPI_READBACK_EN
                            rx_shift <= {rx_shift[RX_W-2:0], spi_miso};
`endif
                        end else if (bit_cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            // next bit is presented on the falling edge only
                            bit_cnt  <= bit_cnt - BIT_W'(1);
                            spi_sclk <= 1'b0;
                            spi_mosi <= cmd_q[bit_cnt - BIT_W'(1)];
                        end
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        state     <= GAP;
                        phase_cnt <= '0;
                        spi_cs_n  <= 1'b1;
`ifdef ADAU_SPI_READBACK_EN
                        rx_data   <= rx_shift;
                        rx_valid  <= 1'b1;
`endif
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        state     <= IDLE;
                        phase_cnt <= '0;
                        spi_ready <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PH_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase_cnt <= '0;
                    spi_ready <= 1'b1;
                    spi_cs_n  <= 1'b1;
                    spi_sclk  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adau_spi_master.sv
// Scoreboard bench for adau_spi_master: expected frames are queued by the stimulus
// thread, a monitor thread decodes CS/SCLK/MOSI and pops/compares at each frame end.
`timescale 1ns/1ps
module tb_adau_spi_master;
    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned CS_GAP    = 4;
    localparam int          READY_LAT = 269;
    localparam int          BOUND     = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] command = '0;
    logic        command_valid = 1'b0;
    logic        spi_ready;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;

    adau_spi_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk(clk),
        .reset(reset),
        .command(command),
        .command_valid(command_valid),
        .spi_ready(spi_ready),
        .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .rx_data(rx_data),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  rx_q[$];
    int n_pushed = 0;
    int frames_checked = 0;
    int frames_started = 0;
    int abort_req = 0;
    int abort_seen = 0;
    int mon_bits = 0;
    int gap_cnt = 0;
    int viol = 0;
    int rx_seen = 0;
    bit b2b = 1'b0;
    logic [31:0] miso_word = 32'h0000_00A5;

    logic [31:0] init_words [15] = '{
        32'h0040_0001, 32'h0040_0200, 32'h0040_1500, 32'h0040_1600, 32'h0040_1700,
        32'h0040_F800, 32'h0040_F900, 32'h0040_1940, 32'h0040_1A00, 32'h0040_1C21,
        32'h0040_1E41, 32'h0040_2003, 32'h0040_2103, 32'h0040_F201, 32'h0040_FA01
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Decodes the SPI pins at each negedge and drives the MISO model
    task automatic monitor();
        logic        pc = 1'b1;
        logic        ps = 1'b1;
        logic        pm = 1'b0;
        logic [31:0] word = '0;
        logic [31:0] e;
        int          fall_idx = 0;
        forever begin
            @(negedge clk);
            if (!pc && !spi_cs_n) begin
                if (!ps && spi_sclk) begin
                    word = {word[30:0], spi_mosi};
                    mon_bits++;
                end
                if (ps && !spi_sclk) begin
                    if (fall_idx < 32) spi_miso = miso_word[31 - fall_idx];
                    fall_idx++;
                end
                if (spi_mosi !== pm && !(ps && !spi_sclk)) viol++;
            end
            if (pc && spi_cs_n && spi_sclk !== ps) viol++;
            if (pc && !spi_cs_n) begin
                if (b2b) check("cs_gap_cycles", 32'(gap_cnt), 32'(CS_GAP));
                frames_started++;
                mon_bits = 0;
                word = '0;
                fall_idx = 0;
            end
            if (!pc && spi_cs_n) begin
                if (abort_req > abort_seen) begin
                    abort_seen++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_frame: got 0x%08h expected no frame", word);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_word", word, e);
                    check("frame_bits", 32'(mon_bits), 32'd32);
                    frames_checked++;
                end
                gap_cnt = 0;
            end
            if (spi_cs_n && !spi_ready) gap_cnt++;
            if (rx_valid === 1'b1) begin
                rx_seen++;
                if (rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%02h expected no rx_valid", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
                end
            end
            pc = spi_cs_n;
            ps = spi_sclk;
            pm = spi_mosi;
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (spi_ready !== 1'b1 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (spi_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within %0d cycles", spi_ready, BOUND);
        end
    endtask

    // Presents one command at a ready negedge; returns after the accepting posedge
    task automatic send(input logic [31:0] w, input bit expect_it);
        wait_ready();
        command = w;
        command_valid = 1'b1;
        if (expect_it) begin
            exp_q.push_back(w);
            n_pushed++;
`ifdef ADAU_SPI_READBACK_EN
            rx_q.push_back(8'hA5);
`endif
        end
        @(posedge clk);
    endtask

    initial begin
        int bad;
        int k;
        int starts_before;
        int rx_before;
        fork
            monitor();
        join_none

        // reset held with a pending command: nothing may be accepted
        reset = 1'b0;
        command = 32'hFFFF_FFFF;
        command_valid = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (spi_cs_n !== 1'b1 || spi_ready !== 1'b1) bad++;
        end
        check("rst_no_accept", 32'(bad), 32'd0);
        check("rst_ready", 32'(spi_ready), 32'd1);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd1);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        command_valid = 1'b0;
        reset = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (spi_ready !== 1'b1 || spi_cs_n !== 1'b1 || spi_sclk !== 1'b1) bad++;
        end
        check("idle_steady", 32'(bad), 32'd0);

        // single frame and ready latency
        send(32'h0040_1500, 1'b1);
        @(negedge clk);
        command_valid = 1'b0;
        k = 1;
        while (spi_ready !== 1'b1 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check("ready_latency", 32'(k), 32'(READY_LAT));

        // back-to-back init sequence with command_valid held high
        b2b = 1'b1;
        for (int i = 0; i < 15; i++) send(init_words[i], 1'b1);
        @(negedge clk);
        command_valid = 1'b0;
        wait_ready();
        b2b = 1'b0;

        // command and command_valid disturbed mid-frame
        starts_before = frames_started;
        send(32'h0040_1640, 1'b1);
        @(negedge clk);
        command_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            command = 32'hFFFF_0000 ^ 32'(i);
            command_valid = i[0];
        end
        command_valid = 1'b0;
        wait_ready();
        repeat (300) @(negedge clk);
        check("no_extra_frame", 32'(frames_started - starts_before), 32'd1);

        // reset while bit 10 is on the wire
        abort_req++;
        send(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        command_valid = 1'b0;
        k = 0;
        while (mon_bits < 21 && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check("abort_at_bit10", 32'(mon_bits), 32'd21);
        rx_before = rx_seen;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_ready", 32'(spi_ready), 32'd1);
        check("abort_rx_valid", 32'(rx_valid), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_rx", 32'(rx_seen), 32'(rx_before));
        send(32'h0040_0001, 1'b1);
        @(negedge clk);
        command_valid = 1'b0;
        wait_ready();

        // readback frame; MISO model returns 0xA5 in the data byte
        send(32'h0140_1500, 1'b1);
        @(negedge clk);
        command_valid = 1'b0;
        wait_ready();
        repeat (20) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frames_checked", 32'(frames_checked), 32'(n_pushed));
        check("pin_rule_violations", 32'(viol), 32'd0);
`ifdef ADAU_SPI_READBACK_EN
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        check("rx_last", 32'(rx_data), 32'h0000_00A5);
`else
        check("rx_never_valid", 32'(rx_seen), 32'd0);
        check("rx_data_tied", 32'(rx_data), 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adau_spi_master.md
ADAU_SPI_MASTER -- requirements
Module: adau_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, the SPI clock half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter CS_GAP, default 4, the number of clk cycles spi_cs_n is held high after a frame (legal range 1..255).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 command  input  32  frame to send, MSB first: chip-address byte, 16-bit subaddress, data byte.
REQ-006 command_valid  input  1  command is valid.
REQ-007 spi_ready  output  1  block can accept a command.
REQ-008 spi_cs_n  output  1  ADAU chip select (CLATCH), active low.
REQ-009 spi_sclk  output  1  SPI clock (CCLK); idles high.
REQ-010 spi_mosi  output  1  serial data to codec (CDATA).
REQ-011 spi_miso  input  1  serial data from codec (COUT).
REQ-012 rx_data  output  8  last byte shifted in (readback only).
REQ-013 rx_valid  output  1  one-cycle strobe: rx_data updated (readback only).

Function
REQ-014 SHALL implement states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 SHALL drive spi_ready high only in IDLE.
REQ-016 SHALL accept a command on the rising edge where command_valid and spi_ready are both high, latch all 32 bits, and enter SETUP.
REQ-017 SHALL ignore command and command_valid in all other states; the latched copy is the only data source for the frame.
REQ-018 On the cycle after acceptance, SHALL drive spi_cs_n low, spi_sclk high, and spi_mosi to command[31]; spi_ready SHALL be low.
REQ-019 SETUP SHALL last CLK_DIV cycles.
REQ-020 In SHIFT, each of the 32 bits SHALL take 2*CLK_DIV cycles: spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-021 spi_mosi SHALL change only at spi_sclk falling edges, and SHALL hold steady through each low and high phase.
REQ-022 Bits SHALL be sent in order 31 down to 0.
REQ-023 HOLD SHALL start after the high phase of bit 0; it SHALL keep spi_cs_n low and spi_sclk high for CLK_DIV cycles.
REQ-024 In GAP, spi_cs_n SHALL be high for CS_GAP cycles, then the block SHALL return to IDLE.
REQ-025 spi_ready SHALL be high exactly 66*CLK_DIV+CS_GAP+1 cycles after the accepting edge (CLK_DIV=4, CS_GAP=4: 269).
REQ-026 If command_valid is high when IDLE is entered, the next frame SHALL be accepted on that cycle (back-to-back frames, gap exactly CS_GAP).
REQ-027 Bit counter SHALL be 5 bits and the phase counter 8 bits; neither SHALL wrap during a frame.
REQ-028 spi_sclk SHALL never toggle while spi_cs_n is high.

Reset
REQ-029 With reset low at a rising edge, next cycle: state IDLE, spi_ready=1, spi_cs_n=1, spi_sclk=1, spi_mosi=0, rx_data=0, rx_valid=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no rx_valid pulse, and SHALL drive spi_cs_n high on the next cycle.
REQ-031 No command SHALL be accepted on a cycle where reset is low.

Configuration
REQ-032 Macro ADAU_SPI_READBACK_EN SHALL enable readback capture.
REQ-033 With the macro defined, spi_miso SHALL be sampled on the clk cycle of each spi_sclk rising edge into an 8-bit shift register (MSB first).
REQ-034 With the macro defined, when spi_cs_n rises, rx_data SHALL load the last 8 bits sampled and rx_valid SHALL pulse for one cycle.
REQ-035 Without the macro, rx_data and rx_valid SHALL be tied to 0, spi_miso SHALL be unused, and the port list SHALL be unchanged.

Verification
REQ-036 Reset, then hold command_valid=0 -> spi_ready=1, spi_cs_n=1, spi_sclk=1 steady for 100 cycles.
REQ-037 Send command 0x00401500 with CLK_DIV=4 -> 32 sclk rising edges, MOSI sampled at those edges = 0x00401500, spi_ready back high at +269 cycles.
REQ-038 Present 15 ADAU init words back-to-back with command_valid held high -> every word received intact, cs_n high for exactly 4 cycles between frames.
REQ-039 Change command and toggle command_valid during a frame for 0x004016_40 -> transmitted bits still 0x00401640, and no extra frame is started.
REQ-040 Assert reset at bit 10 of a frame -> spi_cs_n high next cycle, spi_ready high, no rx_valid; next frame 0x00400001 sent correctly.
REQ-041 Readback build, MISO model returns 0xA5 in the last byte of 0x01401500 -> rx_valid pulses once, rx_data=0xA5; non-readback build -> rx_valid stays 0.
